// File: rtl/mem_arbiter_pkg.sv
// Shared CPU bus definitions: arbiter state encoding, transfer size
// codes and the latched memory request bundle.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } arb_state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [3:0] SEL_ALL = 4'b1111;

   typedef struct packed {
      logic [31:0] addr;
      logic        rw;
      logic [1:0]  size;
      logic [3:0]  wen;
      logic [31:0] wdata;
   } mem_req_t;

   // Instruction fills are always full-word reads.
   function automatic mem_req_t ifetch_req(input logic [31:0] addr);
      mem_req_t r;
      r.addr  = addr;
      r.rw    = 1'b0;
      r.size  = SIZE_WORD;
      r.wen   = SEL_ALL;
      r.wdata = '0;
      return r;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single memory bus.
// Ports: aclk/areset; i_* instruction-cache request and ready/data;
// d_* data-cache request and ready/data; mem_* bus request/response;
// owner reports the current grant (00 none, 01 instr, 10 data).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter bit D_FIRST      = 1'b1
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        i_strobe,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic [31:0] i_data,
   input  logic        d_strobe,
   input  logic [31:0] d_addr,
   input  logic        d_rw,
   input  logic [1:0]  d_size,
   input  logic [3:0]  d_wen,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_data,
   output logic [31:0] mem_a,
   output logic        mem_access,
   output logic        mem_write,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_st_data,
   input  logic [31:0] mem_data,
   input  logic        mem_ready,
   output logic [1:0]  owner
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   arb_state_e    state_q, state_d;
   logic [CW-1:0] starve_q, starve_d;
   mem_req_t      req_q, req_d;
   logic          pick_i;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q  <= IDLE;
         starve_q <= '0;
         req_q    <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         req_q    <= req_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      req_d    = req_q;
      pick_i   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A starved fetch overrides the static tie priority.
            if (i_strobe && d_strobe)
               pick_i = (starve_q == LIM) || !D_FIRST;
            else
               pick_i = i_strobe;
            if (i_strobe || d_strobe) begin
               if (pick_i) begin
                  state_d  = GNT_I;
                  req_d    = ifetch_req(i_addr);
                  starve_d = '0;
               end else begin
                  state_d     = GNT_D;
                  req_d.addr  = d_addr;
                  req_d.rw    = d_rw;
                  req_d.size  = d_size;
                  req_d.wen   = d_wen;
                  req_d.wdata = d_wdata;
                  if (i_strobe && (starve_q != LIM))
                     starve_d = starve_q + CW'(1);
               end
            end
         end
         GNT_I, GNT_D: begin
            // Always pass through IDLE so the winner can drop its strobe.
            if (mem_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_access  = (state_q != IDLE);
   assign owner       = state_q;
   assign mem_a       = req_q.addr;
   assign mem_write   = req_q.rw;
   assign mem_size    = req_q.size;
   assign mem_sel     = req_q.wen;
   assign mem_st_data = req_q.wdata;

   assign i_ready = (state_q == GNT_I) && mem_ready;
   assign d_ready = (state_q == GNT_D) && mem_ready;
   assign i_data  = i_ready ? mem_data : '0;
   assign d_data  = d_ready ? mem_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with directed reset checks.
// Expected grants and per-cycle responses are queued and checked by a monitor.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int LIMIT = 4;
   localparam bit DF    = 1'b1;
   localparam int NCYC  = 3000;

   logic        aclk = 1'b0;
   logic        areset;
   logic        i_strobe, d_strobe, d_rw, mem_ready;
   logic [31:0] i_addr, d_addr, d_wdata, mem_data;
   logic [1:0]  d_size;
   logic [3:0]  d_wen;
   logic        i_ready, d_ready, mem_access, mem_write;
   logic [31:0] i_data, d_data, mem_a, mem_st_data;
   logic [1:0]  mem_size, owner;
   logic [3:0]  mem_sel;

   always #5 aclk = ~aclk;

   mem_arbiter #(.STARVE_LIMIT(LIMIT), .D_FIRST(DF)) dut (
      .aclk(aclk), .areset(areset),
      .i_strobe(i_strobe), .i_addr(i_addr),
      .i_ready(i_ready), .i_data(i_data),
      .d_strobe(d_strobe), .d_addr(d_addr), .d_rw(d_rw),
      .d_size(d_size), .d_wen(d_wen), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_data(d_data),
      .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
      .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
      .mem_data(mem_data), .mem_ready(mem_ready), .owner(owner)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0]  owner;
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } grant_t;

   typedef struct {
      logic [1:0]  owner;
      logic        ir;
      logic        dr;
      logic [31:0] data;
   } cyc_t;

   grant_t gq[$];
   cyc_t   cq[$];
   bit     mon_en = 1'b0;

   // Monitor: per-cycle response check plus grant payload check.
   grant_t cur;
   logic   prev_acc = 1'b0;
   cyc_t   e;
   always @(negedge aclk) begin
      if (mon_en && cq.size() != 0) begin
         e = cq.pop_front();
         chk("owner", 32'(owner), 32'(e.owner));
         chk("mem_access", 32'(mem_access), 32'(e.owner != 2'b00));
         chk("i_ready", 32'(i_ready), 32'(e.ir));
         chk("d_ready", 32'(d_ready), 32'(e.dr));
         if (e.ir) chk("i_data", i_data, e.data);
         if (e.dr) chk("d_data", d_data, e.data);
         if (mem_access && !prev_acc) begin
            if (gq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL grant_extra: got owner %0d want none", owner);
            end else begin
               cur = gq.pop_front();
            end
         end
         if (mem_access) begin
            chk("gnt_owner", 32'(owner), 32'(cur.owner));
            chk("mem_a", mem_a, cur.addr);
            chk("mem_write", 32'(mem_write), 32'(cur.wr));
            chk("mem_size", 32'(mem_size), 32'(cur.size));
            chk("mem_sel", 32'(mem_sel), 32'(cur.sel));
            chk("mem_st_data", mem_st_data, cur.wdata);
         end
         prev_acc = mem_access;
      end
   end

   // Reference model state: who holds the bus and how long the fetch waited.
   int          m_owner, m_starve, win;
   logic        p_is, p_ds, p_drw, p_mr;
   logic [31:0] p_ia, p_da, p_dwd;
   logic [1:0]  p_dsz;
   logic [3:0]  p_dwen;
   logic        s_i_rdy, s_d_rdy;
   bit          i_busy, d_busy, starve_ph, drain;
   int          i_gap, d_gap;
   cyc_t        ne;

   initial begin
      areset = 1'b1;
      i_strobe = 0; d_strobe = 0; d_rw = 0; mem_ready = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; mem_data = 0;
      d_size = 0; d_wen = 0;
      #1;
      chk("rst_access", 32'(mem_access), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_mem_a", mem_a, 0);
      chk("rst_sel", 32'(mem_sel), 0);
      chk("rst_size", 32'(mem_size), 0);
      chk("rst_write", 32'(mem_write), 0);
      chk("rst_st_data", mem_st_data, 0);
      mem_ready = 1'b1;
      i_strobe = 1'b1;
      d_strobe = 1'b1;
      #1;
      chk("rst_i_ready", 32'(i_ready), 0);
      chk("rst_d_ready", 32'(d_ready), 0);
      mem_ready = 0; i_strobe = 0; d_strobe = 0;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;

      m_owner = 0; m_starve = 0;
      p_is = 0; p_ds = 0; p_drw = 0; p_mr = 0;
      p_ia = 0; p_da = 0; p_dwd = 0; p_dsz = 0; p_dwen = 0;
      s_i_rdy = 0; s_d_rdy = 0;
      i_busy = 0; d_busy = 0; i_gap = 0; d_gap = 0;
      mon_en = 1'b1;

      for (int c = 0; c < NCYC; c++) begin
         starve_ph = (c >= 1500 && c < 2000);
         drain = (c >= NCYC - 30);
         @(posedge aclk);
         #1;
         // Model: arbitration happens only from an idle bus.
         if (m_owner == 0) begin
            if (p_is && p_ds)
               win = (m_starve == LIMIT || !DF) ? 1 : 2;
            else if (p_is)
               win = 1;
            else if (p_ds)
               win = 2;
            else
               win = 0;
            if (win == 1) begin
               m_starve = 0;
               gq.push_back('{2'b01, p_ia, 1'b0, 2'b10, 4'hF, 32'h0});
            end else if (win == 2) begin
               if (p_is && m_starve < LIMIT) m_starve++;
               gq.push_back('{2'b10, p_da, p_drw, p_dsz, p_dwen, p_dwd});
            end
            m_owner = win;
         end else if (p_mr) begin
            m_owner = 0;
         end

         // Requesters
         if (s_i_rdy) begin
            i_busy = 0; i_strobe = 0;
            i_gap = starve_ph ? 0 : $urandom_range(0, 3);
         end
         if (s_d_rdy) begin
            d_busy = 0; d_strobe = 0;
            d_gap = starve_ph ? 0 : $urandom_range(0, 3);
         end
         if (i_busy && m_owner == 1 && !starve_ph && $urandom_range(0, 7) == 0)
            i_strobe = 0;
         if (d_busy && m_owner == 2 && !starve_ph && $urandom_range(0, 7) == 0)
            d_strobe = 0;
         if (!i_busy && !drain) begin
            if (i_gap > 0) i_gap--;
            else if (starve_ph || $urandom_range(0, 1) == 1) begin
               i_busy = 1; i_strobe = 1; i_addr = $urandom;
            end
         end
         if (!d_busy && !drain) begin
            if (d_gap > 0) d_gap--;
            else if (starve_ph || $urandom_range(0, 1) == 1) begin
               d_busy = 1; d_strobe = 1;
               d_addr = $urandom; d_rw = 1'($urandom);
               d_size = 2'($urandom_range(0, 2));
               d_wen = 4'($urandom); d_wdata = $urandom;
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            d_addr = $urandom; d_wdata = $urandom;
         end
         if ($urandom_range(0, 3) == 0) i_addr = $urandom;

         // Memory responder, including stray pulses on an idle bus.
         mem_data = $urandom;
         if (mem_access)
            mem_ready = drain || ($urandom_range(0, 2) == 0);
         else
            mem_ready = ($urandom_range(0, 7) == 0);

         ne.owner = 2'(m_owner);
         ne.ir = (m_owner == 1) && mem_ready;
         ne.dr = (m_owner == 2) && mem_ready;
         ne.data = mem_data;
         cq.push_back(ne);

         p_is = i_strobe; p_ds = d_strobe; p_mr = mem_ready;
         p_ia = i_addr; p_da = d_addr; p_drw = d_rw;
         p_dsz = d_size; p_dwen = d_wen; p_dwd = d_wdata;

         @(negedge aclk);
         s_i_rdy = i_ready;
         s_d_rdy = d_ready;
      end

      @(posedge aclk);
      #1;
      mon_en = 1'b0;
      i_strobe = 0; d_strobe = 0; mem_ready = 0;
      chk("grants_left", 32'(gq.size()), 0);
      chk("drain_owner", 32'(owner), 0);

      // Directed fetch: one-cycle latency, then async reset mid-grant.
      @(posedge aclk);
      #1;
      i_strobe = 1'b1;
      i_addr = 32'hBFC0_0000;
      @(negedge aclk);
      chk("lat_idle_owner", 32'(owner), 0);
      chk("lat_idle_access", 32'(mem_access), 0);
      @(negedge aclk);
      chk("fetch_owner", 32'(owner), 1);
      chk("fetch_access", 32'(mem_access), 1);
      chk("fetch_mem_a", mem_a, 32'hBFC0_0000);
      chk("fetch_sel", 32'(mem_sel), 32'hF);
      chk("fetch_write", 32'(mem_write), 0);
      chk("fetch_size", 32'(mem_size), 32'(SIZE_WORD));
      areset = 1'b1;
      #1;
      chk("abort_access", 32'(mem_access), 0);
      chk("abort_owner", 32'(owner), 0);
      chk("abort_mem_a", mem_a, 0);
      chk("abort_sel", 32'(mem_sel), 0);
      i_strobe = 1'b0;
      mem_ready = 1'b1;
      mem_data = 32'h1234_5678;
      #1;
      chk("abort_i_ready", 32'(i_ready), 0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      #1;
      chk("late_i_ready", 32'(i_ready), 0);
      chk("late_d_ready", 32'(d_ready), 0);
      @(posedge aclk);
      #1;
      chk("stray_owner", 32'(owner), 0);
      chk("stray_access", 32'(mem_access), 0);
      mem_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 Parameter D_FIRST, default 1: 1 gives the data port priority on a tie, 0 gives the instruction port priority.
REQ-003 aclk  in  1  sole clock; all state updates on the rising edge.
REQ-004 areset  in  1  asynchronous, active-high reset.
REQ-005 i_strobe  in  1  instruction-cache miss-fill request; held until i_ready.
REQ-006 i_addr  in  32  instruction fetch address.
REQ-007 i_ready  out  1  one-cycle completion pulse to the instruction cache.
REQ-008 i_data  out  32  fetch data; valid while i_ready=1.
REQ-009 d_strobe  in  1  data-cache request; held until d_ready.
REQ-010 d_addr  in  32  data address.
REQ-011 d_rw  in  1  0 = read, 1 = write.
REQ-012 d_size  in  2  transfer size (00 byte, 01 half, 10 word).
REQ-013 d_wen  in  4  byte strobes.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_ready  out  1  one-cycle completion pulse to the data cache.
REQ-016 d_data  out  32  load data; valid while d_ready=1.
REQ-017 mem_a  out  32  address to the AXI interface.
REQ-018 mem_access  out  1  request valid to the AXI interface.
REQ-019 mem_write  out  1  write request.
REQ-020 mem_size  out  2  transfer size.
REQ-021 mem_sel  out  4  byte strobes.
REQ-022 mem_st_data  out  32  store data.
REQ-023 mem_data  in  32  read data.
REQ-024 mem_ready  in  1  one-cycle completion pulse from the AXI interface.
REQ-025 owner  out  2  current grant: 00 none, 01 instruction, 10 data.

Function
REQ-026 The state machine SHALL have exactly three states: IDLE, GNT_I and GNT_D.
REQ-027 From IDLE with exactly one strobe high, the FSM SHALL enter the matching GNT state on the next edge.
REQ-028 From IDLE with both strobes high, the FSM SHALL enter GNT_I if starve_cnt==STARVE_LIMIT, and otherwise SHALL follow D_FIRST.
REQ-029 On the entering edge, the FSM SHALL latch the winner's addr, rw, size, wen and wdata into request registers.
REQ-030 The mem_* outputs SHALL be driven only from the request registers; they are stable during a grant whatever the inputs do.
REQ-031 In GNT_I, the block SHALL force mem_write=0, mem_size=10 and mem_sel=1111.
REQ-032 mem_access SHALL be 1 exactly while in GNT_I or GNT_D, and 0 in IDLE.
REQ-033 While granted, mem_ready=1 SHALL produce the owner's ready pulse in the same cycle (combinational), with mem_data routed to that owner's data output.
REQ-034 The non-owner's ready SHALL stay 0.
REQ-035 After a mem_ready pulse, the FSM SHALL return to IDLE on the next edge and spend at least one cycle there, so the requester can drop its strobe.
REQ-036 Latency from strobe to mem_access is 1 cycle; the minimum gap between grants is 1 IDLE cycle.
REQ-037 The block SHALL ignore mem_ready while in IDLE.
REQ-038 A strobe dropped mid-grant SHALL NOT abort the transfer; the grant completes and the ready pulse is still issued.
REQ-039 starve_cnt, a saturating counter sized for STARVE_LIMIT, SHALL increment on each GNT_D entry while i_strobe=1.
REQ-040 starve_cnt SHALL clear on each GNT_I entry.
REQ-041 starve_cnt SHALL hold on a GNT_D entry with i_strobe=0.
REQ-042 owner SHALL equal 00 in IDLE, 01 in GNT_I and 10 in GNT_D.

Reset
REQ-043 On areset=1, and asynchronously mid-transfer, the block SHALL clear state to IDLE, starve_cnt to 0, and the request registers to 0.
REQ-044 During reset the outputs SHALL be: mem_access=0, i_ready=0, d_ready=0, owner=00, and all mem_* data fields 0.
REQ-045 Any mem_ready that arrives for an aborted transfer SHALL be discarded, because the FSM is in IDLE.

Structure
REQ-046 The state encoding (IDLE=2'b00, GNT_I=2'b01, GNT_D=2'b10) and the size codes SHALL be placed in the shared CPU bus package.
REQ-047 The block SHALL be a single module with no sub-modules.
REQ-048 The request-latch register bank MAY be coded inline.

Verification
REQ-049 Single requester: i_strobe=1 with i_addr=0xBFC00000, and mem_ready pulsed 3 cycles later -> mem_access rises 1 cycle after i_strobe, mem_a=0xBFC00000 and mem_sel=1111, i_ready pulses in the mem_ready cycle, and i_data=mem_data.
REQ-050 Tie with D_FIRST=1: both strobes raised in the same cycle -> GNT_D first, then an IDLE cycle, then GNT_I.
REQ-051 Starvation, STARVE_LIMIT=4: i_strobe held high while 5 back-to-back data writes arrive -> 4 data grants, then an instruction grant, then the 5th data grant.
REQ-052 Input change mid-grant: d_addr changes 0x100 -> 0x200 during GNT_D -> mem_a stays 0x100 until d_ready.
REQ-053 Reset mid-transfer: areset asserted during GNT_I, then a late mem_ready -> mem_access=0 immediately, owner=00, no i_ready pulse.
REQ-054 Stray ready: mem_ready pulsed in IDLE -> i_ready=d_ready=0 and the state is unchanged.
